// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// Writes commit at acceptance; reads sample storage at acceptance and present data in RESP.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ready,
  output logic [31:0] o_rd_data,
  output logic        o_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_wr_q, req_wr_d;
  logic        err_q, err_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [31:0] o_rd_data_q, o_rd_data_d;

  logic             req;
  logic             accept;
  logic             in_range;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_word;
  logic [31:0]      acc_word;
  logic [3:0]       lane_we;
  logic             unused_offset_bits;

  assign req      = i_rd_en | i_wr_en;
  assign accept   = rst_n && (state_q == S_IDLE) && req;
  assign offset   = i_addr - BASE_ADDR;
  // The lower-bound test catches addresses below BASE_ADDR that wrap into range.
  assign in_range = (i_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx      = offset[IDX_W+1:2];
  assign unused_offset_bits = ^offset;

  assign lane_we  = {4{accept && i_wr_en && in_range}} & i_byte_en;
  // Writes (including rd+wr together) and out-of-range reads both return zero.
  assign acc_word = (i_wr_en || !in_range) ? 32'h0 : mem_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          mem[idx] <= i_wr_data[8*gi +: 8];
        end
      end

      assign mem_word[8*gi +: 8] = mem[idx];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_wr_d    = req_wr_q;
    err_d       = err_q;
    rd_word_d   = rd_word_q;
    o_rd_data_d = o_rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          req_wr_d  = i_wr_en;
          err_d     = !in_range;
          rd_word_d = acc_word;
          if (WAIT_CYCLES == 0) begin
            state_d     = S_RESP;
            o_rd_data_d = acc_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          o_rd_data_d = req_wr_q ? 32'h0 : rd_word_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_wr_q    <= 1'b0;
      err_q       <= 1'b0;
      rd_word_q   <= 32'h0;
      o_rd_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_wr_q    <= req_wr_d;
      err_q       <= err_d;
      rd_word_q   <= rd_word_d;
      o_rd_data_q <= o_rd_data_d;
    end
  end

  assign o_ready   = !rst_n || ((state_q == S_IDLE) && !req) || (state_q == S_RESP);
  assign o_err     = (state_q == S_RESP) && err_q;
  assign o_rd_data = o_rd_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances cover WAIT_CYCLES 1, 0 and 3,
// plus an offset base address and reset abandonment mid-access.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  rd_en;
  logic [2:0]  wr_en;
  logic [2:0]  rdy;
  logic [2:0]  err;
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
  logic [31:0] rdata    [3];
  logic [3:0]  be       [3];
  logic [31:0] last_exp [3];
  int          waits    [3];

  exp_t sb[$];
  exp_t e_b2b;
  int   total;
  int   bad;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[0]), .i_rd_en(rd_en[0]), .i_wr_en(wr_en[0]),
    .i_addr(addr[0]), .i_wr_data(wdata[0]), .i_byte_en(be[0]),
    .o_ready(rdy[0]), .o_rd_data(rdata[0]), .o_err(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h100), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[1]), .i_rd_en(rd_en[1]), .i_wr_en(wr_en[1]),
    .i_addr(addr[1]), .i_wr_data(wdata[1]), .i_byte_en(be[1]),
    .o_ready(rdy[1]), .o_rd_data(rdata[1]), .o_err(err[1])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[2]), .i_rd_en(rd_en[2]), .i_wr_en(wr_en[2]),
    .i_addr(addr[2]), .i_wr_data(wdata[2]), .i_byte_en(be[2]),
    .o_ready(rdy[2]), .o_rd_data(rdata[2]), .o_err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one access on instance k, waits for RESP, and scores it against the queued expectation.
  task automatic access(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] exp_d, input logic exp_e, input bit scramble);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    sb.push_back('{data: exp_d, err: exp_e, lat: waits[k] + 1});
    rd_en[k] = rd;
    wr_en[k] = wr;
    addr[k]  = a;
    wdata[k] = d;
    be[k]    = b;
    #1;
    chk("ready_on_req", 32'(rdy[k]), 32'd0);
    chk("rdata_hold", rdata[k], last_exp[k]);
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy[k]) begin
        got = 1'b1;
        break;
      end
      lat++;
      chk("err_in_wait", 32'(err[k]), 32'd0);
      if (scramble) begin
        rd_en[k] = 1'b0;
        wr_en[k] = 1'b1;
        addr[k]  = a ^ 32'h30;
        wdata[k] = ~d;
        be[k]    = 4'hF;
      end
    end
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
    e = sb.pop_front();
    chk("resp_seen", 32'(got), 32'd1);
    chk("rdata", rdata[k], e.data);
    chk("err", 32'(err[k]), 32'(e.err));
    chk("latency", 32'(lat), 32'(e.lat));
    last_exp[k] = e.data;
    $display("txn inst=%0d rd=%0b wr=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d",
             k, rd, wr, a, d, b, rdata[k], err[k], lat);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    waits[0] = 1;
    waits[1] = 0;
    waits[2] = 3;
    rst_n = 3'b000;
    rd_en = 3'b000;
    wr_en = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i]     = 32'h0;
      wdata[i]    = 32'h0;
      be[i]       = 4'h0;
      last_exp[i] = 32'h0;
    end
    rd_en[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(rdy[i]), 32'd1);
      chk("rst_rdata", rdata[i], 32'h0);
      chk("rst_err", 32'(err[i]), 32'd0);
    end
    rd_en[0] = 1'b0;
    rst_n    = 3'b111;

    // WAIT_CYCLES=1 instance
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    access(0, 0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    access(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0);
    access(0, 1, 0, 32'h22, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    access(0, 0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
    access(0, 0, 1, 32'h1000, 32'h99999999, 4'hF, 32'h0, 1'b1, 0);
    access(0, 1, 0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    access(0, 1, 0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);
    access(0, 1, 1, 32'h4, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
    access(0, 1, 0, 32'h7, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
    access(0, 0, 1, 32'h10, 32'h01020304, 4'h0, 32'h0, 1'b0, 0);
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1);
    access(0, 1, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);

    // WAIT_CYCLES=0 instance, window 0x100..0x13F
    access(1, 0, 1, 32'h100, 32'h11111111, 4'hF, 32'h0, 1'b0, 0);
    access(1, 0, 1, 32'h13C, 32'h22222222, 4'hF, 32'h0, 1'b0, 0);
    access(1, 1, 0, 32'h13F, 32'h0, 4'h0, 32'h22222222, 1'b0, 0);
    access(1, 1, 0, 32'h140, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    access(1, 0, 1, 32'hFC, 32'h33333333, 4'hF, 32'h0, 1'b1, 0);
    access(1, 1, 0, 32'h13C, 32'h0, 4'h0, 32'h22222222, 1'b0, 0);
    access(1, 1, 0, 32'h100, 32'h0, 4'h0, 32'h11111111, 1'b0, 0);
    access(1, 0, 1, 32'h110, 32'hA5A50F0F, 4'hF, 32'h0, 1'b0, 0);

    // Request held continuously: one access every two cycles.
    @(negedge clk);
    rd_en[1] = 1'b1;
    addr[1]  = 32'h110;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 0) sb.push_back('{data: 32'hA5A50F0F, err: 1'b0, lat: 1});
      chk("b2b_ready", 32'(rdy[1]), 32'(i % 2));
      if (rdy[1] && sb.size() > 0) begin
        e_b2b = sb.pop_front();
        chk("b2b_rdata", rdata[1], e_b2b.data);
        chk("b2b_err", 32'(err[1]), 32'(e_b2b.err));
        $display("txn inst=1 b2b cycle=%0d rdata=%h err=%0b", i, rdata[1], err[1]);
      end
      @(negedge clk);
    end
    rd_en[1]    = 1'b0;
    sb.delete();
    last_exp[1] = 32'hA5A50F0F;

    // WAIT_CYCLES=3 instance, reset in the middle of a write
    access(2, 0, 1, 32'hC, 32'h00000077, 4'hF, 32'h0, 1'b0, 0);
    access(2, 1, 0, 32'hC, 32'h0, 4'h0, 32'h00000077, 1'b0, 0);
    @(negedge clk);
    wr_en[2] = 1'b1;
    addr[2]  = 32'h8;
    wdata[2] = 32'h55;
    be[2]    = 4'hF;
    #1;
    chk("w3_ready_req", 32'(rdy[2]), 32'd0);
    @(negedge clk);
    chk("w3_ready_wait1", 32'(rdy[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy[2]), 32'd1);
    chk("abort_rdata", rdata[2], 32'h0);
    chk("abort_err", 32'(err[2]), 32'd0);
    @(negedge clk);
    wr_en[2] = 1'b0;
    rst_n[2] = 1'b1;
    last_exp[2] = 32'h0;
    $display("txn inst=2 write addr=00000008 abandoned by reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_resp_ready", 32'(rdy[2]), 32'd1);
      chk("no_resp_err", 32'(err[2]), 32'd0);
    end
    access(2, 1, 0, 32'h8, 32'h0, 4'h0, 32'h00000055, 1'b0, 0);
    access(2, 1, 0, 32'hC, 32'h0, 4'h0, 32'h00000077, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
